// File: rtl/pll_reset_supervisor.sv
// pll_reset_supervisor
// Drives the PLL reset, qualifies the asynchronous PLL locked flag, retries
// the PLL on lock timeout and releases one system reset once lock has been
// stable for the programmed time. Runs on the free-running reference clock.
module pll_reset_supervisor #(
  parameter int unsigned CNT_W               = 16,
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_FILTER_CYCLES  = 1024,
  parameter int unsigned SYS_RST_DELAY       = 64,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 25000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       relock_req_i,
  input  logic       lock_lost_clr_i,
  output logic       pll_rst_o,
  output logic       sys_rst_o,
  output logic       locked_o,
  output logic       lock_lost_o,
  output logic [7:0] retry_cnt_o
);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_FILTER,
    S_DELAY,
    S_RUN
  } state_e;

  // Terminal counts: a phase of N cycles ends on the edge where cnt == N-1.
  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILTER_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(SYS_RST_DELAY - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             locked_meta_q, locked_meta_d;
  logic             locked_s_q, locked_s_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             locked_q, locked_d;
  logic             lock_lost_q, lock_lost_d;
  logic [7:0]       retry_cnt_q, retry_cnt_d;
  logic             lost_set;

  // Next-state, counter, sticky flags and output decode from next state.
  always_comb begin
    locked_meta_d = pll_locked_i;
    locked_s_d    = locked_meta_q;
    state_d       = state_q;
    retry_cnt_d   = retry_cnt_q;
    lost_set      = 1'b0;

    // Relock is checked first so it pre-empts every other transition,
    // including the lock-lost set and the timeout retry increment.
    if (relock_req_i && (state_q != S_RESET_PLL)) begin
      state_d = S_RESET_PLL;
    end else begin
      unique case (state_q)
        S_RESET_PLL: begin
          if (cnt_q == PLL_RST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s_q) begin
            state_d = S_FILTER;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d = S_RESET_PLL;
            if (retry_cnt_q != '1) retry_cnt_d = retry_cnt_q + 8'd1;
          end
        end
        S_FILTER: begin
          if (!locked_s_q) begin
            state_d = S_WAIT_LOCK;
          end else if (cnt_q == FILTER_LAST) begin
            state_d = S_DELAY;
          end
        end
        S_DELAY: begin
          if (!locked_s_q) begin
            state_d = S_RESET_PLL;
          end else if (cnt_q == DELAY_LAST) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            state_d  = S_RESET_PLL;
            lost_set = 1'b1;
          end
        end
        default: state_d = S_RESET_PLL;
      endcase
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Set beats clear when both happen together.
    lock_lost_d = lost_set | (lock_lost_q & ~lock_lost_clr_i);

    pll_rst_d = (state_d == S_RESET_PLL);
    sys_rst_d = (state_d != S_RUN);
    locked_d  = (state_d == S_DELAY) || (state_d == S_RUN);
  end

  // State, counter, synchroniser and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_RESET_PLL;
      cnt_q         <= '0;
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
      retry_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      locked_meta_q <= locked_meta_d;
      locked_s_q    <= locked_s_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_q     <= sys_rst_d;
      locked_q      <= locked_d;
      lock_lost_q   <= lock_lost_d;
      retry_cnt_q   <= retry_cnt_d;
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_o   = sys_rst_q;
  assign locked_o    = locked_q;
  assign lock_lost_o = lock_lost_q;
  assign retry_cnt_o = retry_cnt_q;

endmodule

// File: tb/tb_pll_reset_supervisor.sv
// Directed bench for pll_reset_supervisor with short phase parameters.
// Edge numbering: edge 1 is the first rising edge with rst_n=1; outputs are
// sampled 1 time unit after each edge.
module tb_pll_reset_supervisor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked_i;
  logic       relock_req_i;
  logic       lock_lost_clr_i;
  logic       pll_rst_o;
  logic       sys_rst_o;
  logic       locked_o;
  logic       lock_lost_o;
  logic [7:0] retry_cnt_o;

  int unsigned ecnt     = 0;
  int unsigned compared = 0;
  int unsigned mismatched = 0;

  pll_reset_supervisor #(
    .CNT_W              (16),
    .PLL_RST_CYCLES     (4),
    .LOCK_FILTER_CYCLES (8),
    .SYS_RST_DELAY      (4),
    .LOCK_TIMEOUT_CYCLES(32)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_locked_i   (pll_locked_i),
    .relock_req_i   (relock_req_i),
    .lock_lost_clr_i(lock_lost_clr_i),
    .pll_rst_o      (pll_rst_o),
    .sys_rst_o      (sys_rst_o),
    .locked_o       (locked_o),
    .lock_lost_o    (lock_lost_o),
    .retry_cnt_o    (retry_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic run_to(input int unsigned n);
    while (ecnt < n) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, ecnt, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_pll_rst"}, {7'd0, pll_rst_o}, 8'd1);
    chk({tag, "_sys_rst"}, {7'd0, sys_rst_o}, 8'd1);
    chk({tag, "_locked"},  {7'd0, locked_o},  8'd0);
    chk({tag, "_lost"},    {7'd0, lock_lost_o}, 8'd0);
    chk({tag, "_retry"},   retry_cnt_o, 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    ecnt  = 0;
  endtask

  // Timing of a clean bring-up with locked held high from reset.
  task automatic bringup_checks(input string tag);
    run_to(3);  chk({tag, "_pll_hi_e3"},  {7'd0, pll_rst_o}, 8'd1);
    run_to(4);  chk({tag, "_pll_lo_e4"},  {7'd0, pll_rst_o}, 8'd0);
    run_to(12); chk({tag, "_lck_lo_e12"}, {7'd0, locked_o},  8'd0);
    run_to(13); chk({tag, "_lck_hi_e13"}, {7'd0, locked_o},  8'd1);
    run_to(16); chk({tag, "_sys_hi_e16"}, {7'd0, sys_rst_o}, 8'd1);
    run_to(17); chk({tag, "_sys_lo_e17"}, {7'd0, sys_rst_o}, 8'd0);
    chk({tag, "_retry_e17"}, retry_cnt_o, 8'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    pll_locked_i    = 1'b1;
    relock_req_i    = 1'b0;
    lock_lost_clr_i = 1'b0;

    // Reset values
    tick();
    chk_reset_vals("rst");
    tick();
    rst_n = 1'b1;
    ecnt  = 0;

    // Normal bring-up
    bringup_checks("s1");

    // Lock loss in RUN, recovery, sticky lock_lost
    run_to(20); pll_locked_i = 1'b0;
    run_to(22); chk("s3_sys_still_lo", {7'd0, sys_rst_o}, 8'd0);
    run_to(23);
    chk("s3_sys_hi",  {7'd0, sys_rst_o},   8'd1);
    chk("s3_pll_hi",  {7'd0, pll_rst_o},   8'd1);
    chk("s3_lck_lo",  {7'd0, locked_o},    8'd0);
    chk("s3_lost",    {7'd0, lock_lost_o}, 8'd1);
    pll_locked_i = 1'b1;
    run_to(26); chk("s3_pll_hi_e26", {7'd0, pll_rst_o}, 8'd1);
    run_to(27); chk("s3_pll_lo_e27", {7'd0, pll_rst_o}, 8'd0);
    run_to(35); chk("s3_lck_lo_e35", {7'd0, locked_o},  8'd0);
    run_to(36); chk("s3_lck_hi_e36", {7'd0, locked_o},  8'd1);
    run_to(39); chk("s3_sys_hi_e39", {7'd0, sys_rst_o}, 8'd1);
    run_to(40); chk("s3_sys_lo_e40", {7'd0, sys_rst_o}, 8'd0);
    chk("s3_lost_sticky", {7'd0, lock_lost_o}, 8'd1);
    run_to(41); lock_lost_clr_i = 1'b1;
    run_to(42); lock_lost_clr_i = 1'b0;
    chk("s3_lost_cleared", {7'd0, lock_lost_o}, 8'd0);

    // Relock coincident with lock loss in RUN; relock ignored in RESET_PLL
    run_to(44); pll_locked_i = 1'b0;
    run_to(46); relock_req_i = 1'b1;
    run_to(47); relock_req_i = 1'b0;
    chk("s5_pll_hi",  {7'd0, pll_rst_o},   8'd1);
    chk("s5_sys_hi",  {7'd0, sys_rst_o},   8'd1);
    chk("s5_lck_lo",  {7'd0, locked_o},    8'd0);
    chk("s5_no_lost", {7'd0, lock_lost_o}, 8'd0);
    pll_locked_i = 1'b1;
    run_to(48); relock_req_i = 1'b1;
    run_to(49); relock_req_i = 1'b0;
    run_to(50); chk("s5_pll_hi_e50", {7'd0, pll_rst_o}, 8'd1);
    run_to(51); chk("s5_pll_lo_e51", {7'd0, pll_rst_o}, 8'd0);
    run_to(59); chk("s5_lck_lo_e59", {7'd0, locked_o},  8'd0);
    run_to(60); chk("s5_lck_hi_e60", {7'd0, locked_o},  8'd1);
    run_to(64); chk("s5_sys_lo_e64", {7'd0, sys_rst_o}, 8'd0);
    // Set and clear of lock_lost on the same edge
    run_to(66); pll_locked_i = 1'b0;
    run_to(68); lock_lost_clr_i = 1'b1;
    run_to(69); lock_lost_clr_i = 1'b0;
    chk("s5_set_wins", {7'd0, lock_lost_o}, 8'd1);
    chk("s5_sys_hi_e69", {7'd0, sys_rst_o}, 8'd1);
    pll_locked_i = 1'b1;

    // rst_n pulsed during DELAY, then full bring-up again
    do_reset();
    run_to(14);
    chk("s6_in_delay", {7'd0, locked_o}, 8'd1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("s6_rst");
    rst_n = 1'b1;
    ecnt  = 0;
    bringup_checks("s6");

    // Single-cycle glitch on locked while FILTER cnt=6
    do_reset();
    run_to(9);  pll_locked_i = 1'b0;
    run_to(10); pll_locked_i = 1'b1;
    run_to(12); chk("s4_pll_lo_e12", {7'd0, pll_rst_o}, 8'd0);
    chk("s4_lck_lo_e12", {7'd0, locked_o}, 8'd0);
    run_to(13); chk("s4_pll_lo_e13", {7'd0, pll_rst_o}, 8'd0);
    run_to(20); chk("s4_lck_lo_e20", {7'd0, locked_o},  8'd0);
    run_to(21); chk("s4_lck_hi_e21", {7'd0, locked_o},  8'd1);
    run_to(24); chk("s4_sys_hi_e24", {7'd0, sys_rst_o}, 8'd1);
    run_to(25); chk("s4_sys_lo_e25", {7'd0, sys_rst_o}, 8'd0);
    chk("s4_pll_lo_e25", {7'd0, pll_rst_o}, 8'd0);

    // Lock never arrives: retry every 36 cycles, saturating at 255
    pll_locked_i = 1'b0;
    do_reset();
    run_to(35); chk("s2_pll_lo_e35", {7'd0, pll_rst_o}, 8'd0);
    chk("s2_retry0", retry_cnt_o, 8'd0);
    run_to(36); chk("s2_pll_hi_e36", {7'd0, pll_rst_o}, 8'd1);
    chk("s2_retry1", retry_cnt_o, 8'd1);
    run_to(39); chk("s2_pll_hi_e39", {7'd0, pll_rst_o}, 8'd1);
    run_to(40); chk("s2_pll_lo_e40", {7'd0, pll_rst_o}, 8'd0);
    run_to(72); chk("s2_pll_hi_e72", {7'd0, pll_rst_o}, 8'd1);
    chk("s2_retry2", retry_cnt_o, 8'd2);
    run_to(9179); chk("s2_retry254", retry_cnt_o, 8'd254);
    run_to(9180); chk("s2_retry255", retry_cnt_o, 8'd255);
    run_to(9216); chk("s2_retry_sat", retry_cnt_o, 8'd255);
    chk("s2_pll_hi_e9216", {7'd0, pll_rst_o}, 8'd1);

    // Reset clears the retry counter
    rst_n = 1'b0;
    tick();
    chk_reset_vals("final_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
